module_calc_engine: RTL and testbench

Parametrised keypad calculator core, successor to the fixed 3-digit adder path. It consumes decoded key pulses from the keypad reader and accepts two operands of up to DIGITS decimal digits. It supports addition and subtraction with a sign flag and converts the result to BCD with a sequential double-dabble. Its BCD output drives the existing multiplexed display controller directly, both while an operand is being typed and after '='.

---
 rtl/calc_pkg.sv | 30 +++
 rtl/bin_to_bcd_seq.sv | 62 ++++++
 rtl/module_calc_engine.sv | 198 +++++++++++++++++++
 tb/tb_module_calc_engine.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared key codes, FSM state encoding and parameter sanity helper for the
// keypad calculator core.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_EQ  = 4'hC;
  localparam logic [3:0] KEY_CLR = 4'hD;

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    CALC,
    CONV,
    SHOW
  } state_t;

  // Smallest binary width able to hold the largest operand of 'digits' digits.
  function automatic int min_bin_w(input int digits);
    longint max_val;
    int     w;
    max_val = 1;
    for (int i = 0; i < digits; i++) max_val = max_val * 10;
    max_val = max_val - 1;
    w = 0;
    while ((longint'(1) << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble: one shift per cycle, IN_W cycles per conversion.
// done and the final BCD value are presented combinationally during the last shift.
module bin_to_bcd_seq #(
  parameter int IN_W       = 11,
  parameter int OUT_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [IN_W-1:0]         bin,
  output logic [4*OUT_DIGITS-1:0] bcd,
  output logic                    done
);

  localparam int BCD_W = 4 * OUT_DIGITS;
  localparam int CNT_W = $clog2(IN_W);

  logic [IN_W-1:0]  bin_reg;
  logic [BCD_W-1:0] bcd_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             active_reg;

  logic [BCD_W-1:0] adj;
  logic [BCD_W-1:0] bcd_shift;
  logic [IN_W-1:0]  bin_shift;
  logic             last;

  genvar gi;
  generate
    for (gi = 0; gi < OUT_DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                           : bcd_reg[4*gi +: 4];
    end
  endgenerate

  assign bcd_shift = {adj[BCD_W-2:0], bin_reg[IN_W-1]};
  assign bin_shift = {bin_reg[IN_W-2:0], 1'b0};
  assign last      = (cnt_reg == CNT_W'(IN_W - 1));
  assign done      = active_reg && last;
  assign bcd       = bcd_shift;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      bin_reg    <= '0;
      bcd_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
    end else if (start) begin
      bin_reg    <= bin;
      bcd_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b1;
    end else if (active_reg) begin
      bin_reg <= bin_shift;
      bcd_reg <= bcd_shift;
      cnt_reg <= cnt_reg + CNT_W'(1);
      if (last) active_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/module_calc_engine.sv
// Keypad calculator core: two-operand entry, add/subtract with sign, and a
// sequential binary-to-BCD conversion feeding the display controller.
module module_calc_engine
  import calc_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              key_code,
  input  logic                    key_pulse,
  output logic [4*(DIGITS+1)-1:0] bcd,
  output logic                    neg,
  output logic                    busy,
  output logic                    result_valid,
  output logic                    result_pulse
);

  localparam int OUT_W = 4 * (DIGITS + 1);
  localparam int ENT_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int MAG_W = BIN_W + 1;

  generate
    if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_width
      $error("BIN_W too small to hold DIGITS decimal digits");
    end
  endgenerate

  state_t            state_reg, state_next;
  logic [BIN_W-1:0]  op_a_reg, op_a_next;
  logic [BIN_W-1:0]  op_b_reg, op_b_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              op_sub_reg, op_sub_next;
  logic [ENT_W-1:0]  entry_reg, entry_next;
  logic [OUT_W-1:0]  bcd_reg, bcd_next;
  logic              neg_reg, neg_next;
  logic              neg_pend_reg, neg_pend_next;
  logic              rv_reg, rv_next;
  logic              rp_reg, rp_next;

  logic              conv_start, conv_abort, conv_done;
  logic [OUT_W-1:0]  conv_bcd;
  logic [MAG_W-1:0]  a_ext, b_ext, mag;
  logic              b_gt_a;
  logic              is_digit, digit_room;
  logic [BIN_W-1:0]  d_bin;
  logic [ENT_W-1:0]  entry_shift;

  assign is_digit    = (key_code <= 4'd9);
  assign digit_room  = (cnt_reg < CNT_W'(DIGITS));
  assign d_bin       = BIN_W'(key_code);
  assign entry_shift = {entry_reg[ENT_W-5:0], key_code};

  // One extra bit so the sum of two maximal operands cannot wrap.
  assign a_ext  = {1'b0, op_a_reg};
  assign b_ext  = {1'b0, op_b_reg};
  assign b_gt_a = op_sub_reg && (op_b_reg > op_a_reg);
  assign mag    = !op_sub_reg ? a_ext + b_ext :
                  b_gt_a      ? b_ext - a_ext : a_ext - b_ext;

  always_comb begin
    state_next    = state_reg;
    op_a_next     = op_a_reg;
    op_b_next     = op_b_reg;
    cnt_next      = cnt_reg;
    op_sub_next   = op_sub_reg;
    entry_next    = entry_reg;
    bcd_next      = bcd_reg;
    neg_next      = neg_reg;
    neg_pend_next = neg_pend_reg;
    rv_next       = rv_reg;
    rp_next       = 1'b0;
    conv_start    = 1'b0;
    conv_abort    = 1'b0;

    if (key_pulse && key_code == KEY_CLR) begin
      state_next    = ENTER_A;
      op_a_next     = '0;
      op_b_next     = '0;
      cnt_next      = '0;
      op_sub_next   = 1'b0;
      entry_next    = '0;
      bcd_next      = '0;
      neg_next      = 1'b0;
      neg_pend_next = 1'b0;
      rv_next       = 1'b0;
      conv_abort    = 1'b1;
    end else begin
      case (state_reg)
        ENTER_A, ENTER_B: begin
          if (key_pulse) begin
            if (is_digit) begin
              if (digit_room) begin
                if (state_reg == ENTER_A) op_a_next = op_a_reg * BIN_W'(10) + d_bin;
                else                      op_b_next = op_b_reg * BIN_W'(10) + d_bin;
                cnt_next   = cnt_reg + CNT_W'(1);
                entry_next = entry_shift;
                bcd_next   = {4'h0, entry_shift};
                neg_next   = 1'b0;
              end
            end else if (key_code == KEY_ADD || key_code == KEY_SUB) begin
              if (state_reg == ENTER_A) begin
                op_sub_next = (key_code == KEY_SUB);
                state_next  = ENTER_B;
                cnt_next    = '0;
                entry_next  = '0;
                bcd_next    = '0;
              end else if (cnt_reg == '0) begin
                op_sub_next = (key_code == KEY_SUB);
              end
            end else if (key_code == KEY_EQ) begin
              state_next = CALC;
            end
          end
        end
        CALC: begin
          conv_start    = 1'b1;
          neg_pend_next = b_gt_a;
          state_next    = CONV;
        end
        CONV: begin
          if (conv_done) begin
            bcd_next   = conv_bcd;
            neg_next   = neg_pend_reg;
            rv_next    = 1'b1;
            rp_next    = 1'b1;
            state_next = SHOW;
          end
        end
        SHOW: begin
          // A digit starts a fresh calculation already holding that digit.
          if (key_pulse && is_digit) begin
            state_next  = ENTER_A;
            op_a_next   = d_bin;
            op_b_next   = '0;
            op_sub_next = 1'b0;
            cnt_next    = CNT_W'(1);
            entry_next  = ENT_W'(key_code);
            bcd_next    = OUT_W'(key_code);
            neg_next    = 1'b0;
            rv_next     = 1'b0;
          end
        end
        default: state_next = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ENTER_A;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      cnt_reg      <= '0;
      op_sub_reg   <= 1'b0;
      entry_reg    <= '0;
      bcd_reg      <= '0;
      neg_reg      <= 1'b0;
      neg_pend_reg <= 1'b0;
      rv_reg       <= 1'b0;
      rp_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_a_reg     <= op_a_next;
      op_b_reg     <= op_b_next;
      cnt_reg      <= cnt_next;
      op_sub_reg   <= op_sub_next;
      entry_reg    <= entry_next;
      bcd_reg      <= bcd_next;
      neg_reg      <= neg_next;
      neg_pend_reg <= neg_pend_next;
      rv_reg       <= rv_next;
      rp_reg       <= rp_next;
    end
  end

  bin_to_bcd_seq #(
    .IN_W       (MAG_W),
    .OUT_DIGITS (DIGITS + 1)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .abort (conv_abort),
    .bin   (mag),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  assign bcd          = bcd_reg;
  assign neg          = neg_reg;
  assign busy         = (state_reg == CALC) || (state_reg == CONV);
  assign result_valid = rv_reg;
  assign result_pulse = rp_reg;

endmodule

// File: tb/tb_module_calc_engine.sv
// Directed and randomized key sequences for module_calc_engine, checked
// against a decimal arithmetic model of the calculator.
module tb_module_calc_engine;
  import calc_pkg::*;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_code = 4'h0;
  logic        key_pulse = 1'b0;
  logic [15:0] bcd;
  logic        neg, busy, result_valid, result_pulse;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model of what the user has typed and what the display should show.
  int          m_a, m_b, m_na, m_nb, m_phase; // phase: 0 entering A, 1 entering B, 2 showing result
  bit          m_sub, m_neg, m_rv;
  logic [15:0] m_bcd;

  module_calc_engine #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_code     (key_code),
    .key_pulse    (key_pulse),
    .bcd          (bcd),
    .neg          (neg),
    .busy         (busy),
    .result_valid (result_valid),
    .result_pulse (result_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic void m_reset();
    m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_phase = 0;
    m_sub = 1'b0; m_neg = 1'b0; m_rv = 1'b0; m_bcd = '0;
  endfunction

  function automatic void m_key(input logic [3:0] k);
    if (k <= 4'd9) begin
      if (m_phase == 2) begin
        m_reset();
        m_a = int'(k); m_na = 1; m_bcd = to_bcd(m_a);
      end else if (m_phase == 0 && m_na < DIGITS) begin
        m_a = m_a * 10 + int'(k); m_na++; m_bcd = to_bcd(m_a); m_neg = 1'b0;
      end else if (m_phase == 1 && m_nb < DIGITS) begin
        m_b = m_b * 10 + int'(k); m_nb++; m_bcd = to_bcd(m_b); m_neg = 1'b0;
      end
    end else if (k == KEY_ADD || k == KEY_SUB) begin
      if (m_phase == 0) begin
        m_sub = (k == KEY_SUB); m_phase = 1; m_bcd = '0;
      end else if (m_phase == 1 && m_nb == 0) begin
        m_sub = (k == KEY_SUB);
      end
    end else if (k == KEY_CLR) begin
      m_reset();
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_code  = k;
    key_pulse = 1'b1;
    @(negedge clk);
    key_pulse = 1'b0;
    m_key(k);
  endtask

  task automatic press_chk(input logic [3:0] k, input string tag);
    press(k);
    check({tag, "_bcd"}, 32'(bcd), 32'(m_bcd));
    check({tag, "_neg"}, 32'(neg), 32'(m_neg));
    check({tag, "_rv"},  32'(result_valid), 32'(m_rv));
  endtask

  // '=' in cycle 0; optional extra key injected in cycle inj_cyc while busy.
  task automatic do_equals(input int inj_cyc, input logic [3:0] inj_key, input string tag);
    int busy_n, pulse_n, pulse_at, r;
    busy_n = 0; pulse_n = 0; pulse_at = 0;
    @(negedge clk);
    key_code  = KEY_EQ;
    key_pulse = 1'b1;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(negedge clk);
      key_pulse = 1'b0;
      if (busy) busy_n++;
      if (result_pulse) begin
        pulse_n++;
        if (pulse_at == 0) pulse_at = cyc;
      end
      if (cyc == inj_cyc) begin
        key_code  = inj_key;
        key_pulse = 1'b1;
      end
    end
    if (inj_cyc != 0 && inj_key == KEY_CLR) begin
      m_reset();
      check({tag, "_npulse"}, 32'(pulse_n), 32'd0);
      check({tag, "_busy"},   32'(busy), 32'd0);
    end else begin
      r     = m_sub ? m_a - m_b : m_a + m_b;
      m_neg = (r < 0);
      m_bcd = to_bcd(r < 0 ? -r : r);
      m_rv  = 1'b1;
      m_phase = 2;
      check({tag, "_pulse_at"}, 32'(pulse_at), 32'(BIN_W + 3));
      check({tag, "_npulse"},   32'(pulse_n), 32'd1);
      check({tag, "_busy_n"},   32'(busy_n), 32'(BIN_W + 2));
    end
    check({tag, "_bcd"}, 32'(bcd), 32'(m_bcd));
    check({tag, "_neg"}, 32'(neg), 32'(m_neg));
    check({tag, "_rv"},  32'(result_valid), 32'(m_rv));
  endtask

  initial begin
    logic [3:0] k;
    int         nk, r;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_bcd",  32'(bcd), 32'd0);
    check("rst_neg",  32'(neg), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rv",   32'(result_valid), 32'd0);
    check("rst_rp",   32'(result_pulse), 32'd0);

    // 12 + 34
    press_chk(4'd1, "t1_k1"); press_chk(4'd2, "t1_k2"); press_chk(KEY_ADD, "t1_add");
    press_chk(4'd3, "t1_k3"); press_chk(4'd4, "t1_k4");
    do_equals(0, 4'h0, "t1_eq");
    check("t1_fixed", 32'(bcd), 32'h0046);

    // 5 - 20, then a new digit
    press_chk(KEY_CLR, "t2_clr");
    press_chk(4'd5, "t2_k5"); press_chk(KEY_SUB, "t2_sub");
    press_chk(4'd2, "t2_k2"); press_chk(4'd0, "t2_k0");
    do_equals(0, 4'h0, "t2_eq");
    check("t2_fixed", 32'({neg, bcd}), 32'h10015);
    press_chk(KEY_EQ, "t2_eq_ignored");
    press_chk(4'd7, "t2_k7");
    check("t2_fixed7", 32'({result_valid, neg, bcd}), 32'h0007);

    // 999 + 999, then 1,2,3,4 with the fourth digit dropped
    press_chk(KEY_CLR, "t3_clr");
    for (int i = 0; i < 3; i++) press(4'd9);
    press(KEY_ADD);
    for (int i = 0; i < 3; i++) press(4'd9);
    do_equals(0, 4'h0, "t3_eq");
    check("t3_fixed", 32'(bcd), 32'h1998);
    press(4'd1); press(4'd2); press(4'd3);
    press_chk(4'd4, "t3_k4_drop");
    check("t3_fixed123", 32'(bcd), 32'h0123);

    // empty A, operator replaced, 0 - 4
    press_chk(KEY_CLR, "t4_clr");
    press_chk(KEY_ADD, "t4_add"); press_chk(KEY_SUB, "t4_sub"); press_chk(4'd4, "t4_k4");
    press_chk(KEY_ADD, "t4_add_ignored");
    do_equals(0, 4'h0, "t4_eq");
    check("t4_fixed", 32'({neg, bcd}), 32'h10004);

    // clear during CONV (cycle 6 = 5th CONV cycle) aborts the conversion
    press_chk(KEY_CLR, "t5_clr");
    press(4'd1); press(KEY_ADD); press(4'd2);
    do_equals(6, KEY_CLR, "t5_abort");
    press_chk(4'd3, "t5_enter_a");

    // digit key during busy is ignored
    press_chk(KEY_CLR, "t6_clr");
    press(4'd2); press(KEY_ADD); press(4'd5);
    do_equals(3, 4'd8, "t6_busy_key");
    check("t6_fixed", 32'(bcd), 32'h0007);

    // rst mid-entry
    press(4'd4); press(4'd5);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_reset();
    check("t7_rst_out", 32'({busy, result_valid, result_pulse, neg, bcd}), 32'd0);
    press_chk(4'd7, "t7_k7");
    do_equals(0, 4'h0, "t7_eq");
    check("t7_fixed", 32'(bcd), 32'h0007);

    // randomized key sequences against the model
    for (int it = 0; it < 25; it++) begin
      press_chk(KEY_CLR, "rnd_clr");
      nk = $urandom_range(3, 9);
      for (int j = 0; j < nk; j++) begin
        r = $urandom_range(0, 99);
        if (r < 70)      k = 4'($urandom_range(0, 9));
        else if (r < 80) k = KEY_ADD;
        else if (r < 90) k = KEY_SUB;
        else             k = 4'($urandom_range(14, 15));
        press_chk(k, "rnd_key");
      end
      do_equals(0, 4'h0, "rnd_eq");
      k = ($urandom_range(0, 1) == 0) ? KEY_ADD : KEY_SUB;
      press_chk(k, "rnd_show_op");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
